// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared opcodes, bus size codes and FSM encoding for the memory stage
package mem_access_unit_pkg;
   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LWL = 6'h22;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_LWR = 6'h26;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SWL = 6'h2a;
   localparam logic [5:0] OP_SW  = 6'h2b;
   localparam logic [5:0] OP_SWR = 6'h2e;
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;
   function automatic logic is_unaligned(input logic [5:0] op);
      return op inside {OP_LWL, OP_LWR, OP_SWL, OP_SWR};
   endfunction
   function automatic logic is_load(input logic [5:0] op);
      return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWL, OP_LWR};
   endfunction
   function automatic logic is_store(input logic [5:0] op);
      return op inside {OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR};
   endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering for stores and extend/merge of load data
module mem_lane_align import mem_access_unit_pkg::*; #(
   parameter int ADDR_W = 32
) (
   input  logic [5:0]        op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       rt,
   output logic [3:0]        wstrb,
   output logic [31:0]       wdata,
   output logic [1:0]        size,
   output logic [ADDR_W-1:0] bus_addr,
   input  logic [5:0]        rop,
   input  logic [1:0]        ra,
   input  logic [31:0]       rrt,
   input  logic [31:0]       rdata,
   output logic [31:0]       result
);
   logic [1:0] a;
   logic [7:0] b;
   logic [15:0] h;
   assign a = addr[1:0];
   assign b = rdata[{ra, 3'b000} +: 8];
   assign h = rdata[{ra[1], 4'b0000} +: 16];
   always_comb begin
      wstrb = 4'b0000;
      wdata = rt;
      size = SZ_WORD;
      bus_addr = addr;
      case (op)
         OP_SB: begin wstrb = 4'b0001 << a; wdata = {4{rt[7:0]}}; size = SZ_BYTE; end
         OP_SH: begin wstrb = a[1] ? 4'b1100 : 4'b0011; wdata = {2{rt[15:0]}}; size = SZ_HALF; end
         OP_SW: wstrb = 4'b1111;
         OP_SWL: begin wstrb = 4'b1111 >> ~a; wdata = rt >> {~a, 3'b000}; end
         OP_SWR: begin wstrb = 4'b1111 << a; wdata = rt << {a, 3'b000}; end
         OP_LB, OP_LBU: size = SZ_BYTE;
         OP_LH, OP_LHU: size = SZ_HALF;
         default: ;
      endcase
      if (is_unaligned(op)) bus_addr[1:0] = 2'b00;
   end
   // LWL/LWR keep the rt bytes the memory word does not cover
   always_comb begin
      case (rop)
         OP_LB:   result = {{24{b[7]}}, b};
         OP_LBU:  result = {24'h0, b};
         OP_LH:   result = {{16{h[15]}}, h};
         OP_LHU:  result = {16'h0, h};
         OP_LWL:  result = (rdata << {~ra, 3'b000}) | (rrt & ~(32'hffff_ffff << {~ra, 3'b000}));
         OP_LWR:  result = (rdata >> {ra, 3'b000}) | (rrt & ~(32'hffff_ffff >> {ra, 3'b000}));
         default: result = rdata;
      endcase
   end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store unit with alignment checks and a flush-safe bus transaction FSM
module mem_access_unit import mem_access_unit_pkg::*; #(
   parameter int ADDR_W = 32,
   parameter bit UNALIGNED_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic              flush_i,
   input  logic [5:0]        op_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   input  logic [31:0]       pc_i,
   output logic              stall_o,
   output logic              done_o,
   output logic [31:0]       rdata_o,
   output logic              adel_o,
   output logic              ades_o,
   output logic [31:0]       bad_addr_o,
   output logic              data_req_o,
   output logic              data_wr_o,
   output logic [1:0]        data_size_o,
   output logic [ADDR_W-1:0] data_addr_o,
   output logic [3:0]        data_wstrb_o,
   output logic [31:0]       data_wdata_o,
   input  logic              data_addr_ok_i,
   input  logic [31:0]       data_rdata_i,
   input  logic              data_data_ok_i
);
   state_t state, next;
   logic load, store, mis, go, busy, cancel;
   logic [5:0] op_q;
   logic [1:0] a_q;
   logic [31:0] rt_q, wdata_c, result;
   logic [3:0] wstrb_c;
   logic [1:0] size_c;
   logic [ADDR_W-1:0] addr_c;
   assign load = is_load(op_i) & (UNALIGNED_EN | ~is_unaligned(op_i));
   assign store = is_store(op_i) & (UNALIGNED_EN | ~is_unaligned(op_i));
   assign mis = (op_i == OP_LW || op_i == OP_SW) ? |addr_i[1:0] :
                (op_i == OP_LH || op_i == OP_LHU || op_i == OP_SH) & addr_i[0];
   assign adel_o = valid_i & load & mis;
   assign ades_o = valid_i & store & mis;
   assign bad_addr_o = (adel_o | ades_o) ? 32'(addr_i) : pc_i;
   assign go = valid_i & ~flush_i & (load | store) & ~mis;
   assign busy = state == S_ADDR || state == S_DATA;
   mem_lane_align #(.ADDR_W(ADDR_W)) u_lane (
      .op(op_i), .addr(addr_i), .rt(wdata_i),
      .wstrb(wstrb_c), .wdata(wdata_c), .size(size_c), .bus_addr(addr_c),
      .rop(op_q), .ra(a_q), .rrt(rt_q), .rdata(data_rdata_i), .result(result)
   );
   // a cancelled transaction still drains to data_ok, it just skips RESP
   always_comb begin
      next = state;
      stall_o = 1'b0;
      done_o = 1'b0;
      data_req_o = 1'b0;
      case (state)
         S_IDLE: begin next = go ? S_ADDR : S_IDLE; stall_o = go; end
         S_ADDR: begin next = data_addr_ok_i ? S_DATA : S_ADDR; stall_o = 1'b1; data_req_o = 1'b1; end
         S_DATA: begin next = data_data_ok_i ? ((cancel | flush_i) ? S_IDLE : S_RESP) : S_DATA; stall_o = 1'b1; end
         default: begin next = S_IDLE; done_o = 1'b1; end
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cancel <= 1'b0;
         op_q <= '0;
         a_q <= '0;
         rt_q <= '0;
         rdata_o <= '0;
         data_wr_o <= 1'b0;
         data_size_o <= '0;
         data_addr_o <= '0;
         data_wstrb_o <= '0;
         data_wdata_o <= '0;
      end else begin
         state <= next;
         cancel <= busy & (next != S_IDLE) & (cancel | flush_i);
         if (state == S_IDLE && go) begin
            op_q <= op_i;
            a_q <= addr_i[1:0];
            rt_q <= wdata_i;
            data_wr_o <= store;
            data_size_o <= size_c;
            data_addr_o <= addr_c;
            data_wstrb_o <= wstrb_c;
            data_wdata_o <= wdata_c;
         end
         if (state == S_DATA && data_data_ok_i && !(cancel || flush_i)) rdata_o <= result;
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: vector table, random ops against a byte-level model, and handshake corner cases
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;
   logic clk = 1'b0, rst;
   logic valid_i, flush_i, data_addr_ok_i, data_data_ok_i;
   logic [5:0] op_i;
   logic [31:0] addr_i, wdata_i, pc_i, data_rdata_i;
   logic stall_o, done_o, adel_o, ades_o, data_req_o, data_wr_o;
   logic [31:0] rdata_o, bad_addr_o, data_wdata_o, data_addr_o;
   logic [1:0] data_size_o;
   logic [3:0] data_wstrb_o;
   int errors = 0, checks = 0;
   typedef struct {
      logic [5:0] op;
      logic [31:0] addr, rt, mem, exp_rd;
      logic [3:0] exp_strb;
      logic [31:0] exp_wd;
      bit exp_adel, exp_ades;
   } vec_t;
   vec_t tbl[10];
   logic [5:0] ops[12];
   always #5 clk = ~clk;
   mem_access_unit #(.ADDR_W(32), .UNALIGNED_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .op_i(op_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .pc_i(pc_i), .stall_o(stall_o), .done_o(done_o),
      .rdata_o(rdata_o), .adel_o(adel_o), .ades_o(ades_o), .bad_addr_o(bad_addr_o),
      .data_req_o(data_req_o), .data_wr_o(data_wr_o), .data_size_o(data_size_o),
      .data_addr_o(data_addr_o), .data_wstrb_o(data_wstrb_o), .data_wdata_o(data_wdata_o),
      .data_addr_ok_i(data_addr_ok_i), .data_rdata_i(data_rdata_i), .data_data_ok_i(data_data_ok_i)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   function automatic bit m_load(input logic [5:0] op);
      return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR};
   endfunction
   function automatic bit m_err(input logic [5:0] op, input logic [31:0] addr);
      if (op == OP_LW || op == OP_SW) return addr % 4 != 0;
      if (op == OP_LH || op == OP_LHU || op == OP_SH) return addr % 2 != 0;
      return 1'b0;
   endfunction
   function automatic logic [1:0] m_size(input logic [5:0] op);
      if (op inside {OP_LB, OP_LBU, OP_SB}) return 2'd0;
      if (op inside {OP_LH, OP_LHU, OP_SH}) return 2'd1;
      return 2'd2;
   endfunction
   function automatic logic [31:0] m_busaddr(input logic [5:0] op, input logic [31:0] addr);
      return (op inside {OP_LWL, OP_LWR, OP_SWL, OP_SWR}) ? addr - addr % 4 : addr;
   endfunction
   function automatic logic [31:0] m_rdata(input logic [5:0] op, input int a, input logic [31:0] rt, input logic [31:0] mem);
      logic [7:0] m[4], r[4], o[4];
      for (int i = 0; i < 4; i++) begin m[i] = mem[8*i +: 8]; r[i] = rt[8*i +: 8]; end
      case (op)
         OP_LB:  return {{24{m[a][7]}}, m[a]};
         OP_LBU: return {24'h0, m[a]};
         OP_LH:  return {{16{m[a+1][7]}}, m[a+1], m[a]};
         OP_LHU: return {16'h0, m[a+1], m[a]};
         OP_LWL: for (int i = 0; i < 4; i++) if (i >= 3 - a) o[i] = m[i-3+a]; else o[i] = r[i];
         OP_LWR: for (int i = 0; i < 4; i++) if (i <= 3 - a) o[i] = m[i+a]; else o[i] = r[i];
         default: return mem;
      endcase
      return {o[3], o[2], o[1], o[0]};
   endfunction
   task automatic m_store(input logic [5:0] op, input int a, input logic [31:0] rt, output logic [3:0] s, output logic [31:0] d);
      logic [7:0] r[4];
      for (int i = 0; i < 4; i++) r[i] = rt[8*i +: 8];
      s = 4'b0000;
      d = 32'h0;
      for (int i = 0; i < 4; i++) begin
         case (op)
            OP_SB:  begin s[i] = i == a; d[8*i +: 8] = r[0]; end
            OP_SH:  begin s[i] = i / 2 == a / 2; d[8*i +: 8] = r[i%2]; end
            OP_SW:  begin s[i] = 1'b1; d[8*i +: 8] = r[i]; end
            OP_SWL: if (i <= a) begin s[i] = 1'b1; d[8*i +: 8] = r[i+3-a]; end
            OP_SWR: if (i >= a) begin s[i] = 1'b1; d[8*i +: 8] = r[i-a]; end
            default: ;
         endcase
      end
   endtask
   // plays a slave that waits aw cycles before addr_ok and dw cycles before data_ok
   task automatic access(input logic [5:0] op, input logic [31:0] addr, rt, mem, input int aw, dw, input bit spur,
                         output logic [31:0] rd, output logic [3:0] st, output logic [31:0] wd, output logic [1:0] sz,
                         output logic [31:0] ba, output logic wr, output int lat, output int reqc, output bit stable, output bit ok);
      int waited = 0, dwaited = 0;
      bit dphase = 0;
      stable = 1; ok = 1; reqc = 0; lat = -1;
      rd = 'x; st = 'x; wd = 'x; sz = 'x; ba = 'x; wr = 'x;
      @(negedge clk);
      valid_i = 1; flush_i = 0; op_i = op; addr_i = addr; wdata_i = rt; pc_i = $urandom;
      data_addr_ok_i = 0; data_data_ok_i = 0;
      #1 if (!stall_o) ok = 0;
      for (int c = 1; c < 60 && lat < 0; c++) begin
         @(negedge clk);
         data_addr_ok_i = 0; data_data_ok_i = 0; data_rdata_i = $urandom;
         #1;
         if (done_o) begin
            lat = c; rd = rdata_o;
            if (stall_o) ok = 0;
         end else begin
            if (!stall_o) ok = 0;
            if (data_req_o) begin
               if (reqc == 0) begin st = data_wstrb_o; wd = data_wdata_o; sz = data_size_o; ba = data_addr_o; wr = data_wr_o; end
               else if ({st, wd, sz, ba, wr} !== {data_wstrb_o, data_wdata_o, data_size_o, data_addr_o, data_wr_o}) stable = 0;
               reqc++;
               if (waited == aw) begin
                  data_addr_ok_i = 1; dphase = 1;
                  if (spur) begin data_data_ok_i = 1; data_rdata_i = ~mem; end
               end else waited++;
            end else if (dphase) begin
               if (dwaited == dw) begin data_data_ok_i = 1; data_rdata_i = mem; end
               else dwaited++;
            end
         end
      end
      @(negedge clk);
      valid_i = 0; data_addr_ok_i = 0; data_data_ok_i = 0;
      #1 if (done_o || stall_o) ok = 0;
   endtask
   task automatic run_chk(input string nm, input logic [5:0] op, input logic [31:0] addr, rt, mem, input int aw, dw, input bit spur);
      logic [31:0] rd, wd, ba, ed;
      logic [3:0] st, es;
      logic [1:0] sz;
      logic wr;
      int lat, reqc;
      bit stable, ok;
      access(op, addr, rt, mem, aw, dw, spur, rd, st, wd, sz, ba, wr, lat, reqc, stable, ok);
      m_store(op, int'(addr % 4), rt, es, ed);
      chk({nm, " latency"}, lat, 3 + aw + dw);
      chk({nm, " req cycles"}, reqc, aw + 1);
      chk({nm, " req stable"}, 32'(stable), 1);
      chk({nm, " stall/done"}, 32'(ok), 1);
      chk({nm, " bus addr"}, ba, m_busaddr(op, addr));
      chk({nm, " size"}, 32'(sz), 32'(m_size(op)));
      chk({nm, " strb"}, 32'(st), 32'(es));
      chk({nm, " wr"}, 32'(wr), 32'(!m_load(op)));
      if (m_load(op)) chk({nm, " rdata"}, rd, m_rdata(op, int'(addr % 4), rt, mem));
      else chk({nm, " wdata"}, wd, ed);
   endtask
   task automatic err_case(input string nm, input logic [5:0] op, input logic [31:0] addr, input bit el, input bit es);
      @(negedge clk);
      valid_i = 1; flush_i = 0; op_i = op; addr_i = addr; pc_i = $urandom;
      #1;
      chk({nm, " adel"}, 32'(adel_o), 32'(el));
      chk({nm, " ades"}, 32'(ades_o), 32'(es));
      chk({nm, " bad_addr"}, bad_addr_o, addr);
      chk({nm, " stall"}, 32'(stall_o), 0);
      @(negedge clk);
      #1 chk({nm, " no req"}, 32'(data_req_o), 0);
      valid_i = 0;
      @(negedge clk);
      #1 chk({nm, " idle req"}, 32'(data_req_o | stall_o), 0);
      chk({nm, " pc"}, bad_addr_o, pc_i);
   endtask
   initial begin
      logic [31:0] rd, wd, ba, held, addr;
      logic [3:0] st;
      logic [1:0] sz;
      logic wr;
      int lat, reqc;
      bit stable, ok;
      logic [5:0] op;
      ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR, OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR};
      tbl[0] = '{OP_SB,  32'h1003, 32'h0000_00ab, 32'h0, 32'h0, 4'b1000, 32'habab_abab, 0, 0};
      tbl[1] = '{OP_LH,  32'h2002, 32'h0, 32'h8001_1234, 32'hffff_8001, 4'b0000, 32'h0, 0, 0};
      tbl[2] = '{OP_LHU, 32'h2002, 32'h0, 32'h8001_1234, 32'h0000_8001, 4'b0000, 32'h0, 0, 0};
      tbl[3] = '{OP_LW,  32'h3001, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 1, 0};
      tbl[4] = '{OP_LWL, 32'h5001, 32'h1122_3344, 32'haabb_ccdd, 32'hccdd_3344, 4'b0000, 32'h0, 0, 0};
      tbl[5] = '{OP_SWR, 32'h6002, 32'h1122_3344, 32'h0, 32'h0, 4'b1100, 32'h3344_0000, 0, 0};
      tbl[6] = '{OP_SH,  32'h7002, 32'h0000_beef, 32'h0, 32'h0, 4'b1100, 32'hbeef_beef, 0, 0};
      tbl[7] = '{OP_SW,  32'h7001, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 0, 1};
      tbl[8] = '{OP_LB,  32'h8001, 32'h0, 32'h1234_8056, 32'hffff_ff80, 4'b0000, 32'h0, 0, 0};
      tbl[9] = '{OP_SWL, 32'h9001, 32'h1122_3344, 32'h0, 32'h0, 4'b0011, 32'h0000_1122, 0, 0};
      rst = 1; valid_i = 0; flush_i = 0; op_i = 0; addr_i = 0; wdata_i = 0; pc_i = 32'hbfc0_0000;
      data_addr_ok_i = 0; data_data_ok_i = 0; data_rdata_i = 0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset outputs", {28'h0, data_req_o, stall_o, done_o, adel_o | ades_o}, 0);
      chk("reset rdata", rdata_o, 0);
      chk("reset bad_addr", bad_addr_o, 32'hbfc0_0000);
      rst = 0;
      for (int i = 0; i < 10; i++) begin
         if (tbl[i].exp_adel || tbl[i].exp_ades) err_case($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].exp_adel, tbl[i].exp_ades);
         else begin
            access(tbl[i].op, tbl[i].addr, tbl[i].rt, tbl[i].mem, 0, 0, 0, rd, st, wd, sz, ba, wr, lat, reqc, stable, ok);
            chk($sformatf("vec%0d latency", i), lat, 3);
            chk($sformatf("vec%0d stall/done", i), 32'(ok), 1);
            if (m_load(tbl[i].op)) chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
            else begin
               chk($sformatf("vec%0d strb", i), 32'(st), 32'(tbl[i].exp_strb));
               chk($sformatf("vec%0d wdata", i), wd, tbl[i].exp_wd);
            end
         end
      end
      run_chk("addr_ok delay", OP_LW, 32'h0000_a000, 32'h0, 32'hdead_beef, 3, 0, 0);
      held = rdata_o;
      repeat (2) @(negedge clk);
      #1 chk("rdata held", rdata_o, held);
      run_chk("spurious data_ok", OP_LBU, 32'h0000_b002, 32'h0, 32'h00c3_0000, 1, 1, 1);
      // flush while waiting for data: drain silently, then a normal LW
      @(negedge clk);
      valid_i = 1; flush_i = 0; op_i = OP_LW; addr_i = 32'h4000; pc_i = 32'h400; data_addr_ok_i = 0; data_data_ok_i = 0;
      @(negedge clk);
      data_addr_ok_i = 1;
      @(negedge clk);
      data_addr_ok_i = 0; flush_i = 1;
      #1 chk("flush stall data", 32'(stall_o), 1);
      @(negedge clk);
      flush_i = 0; valid_i = 0;
      #1 chk("flush drain stall", {31'h0, stall_o}, 1);
      chk("flush drain done", 32'(done_o), 0);
      @(negedge clk);
      #1 chk("flush data_ok stall", 32'(stall_o), 1);
      data_data_ok_i = 1; data_rdata_i = $urandom;
      @(negedge clk);
      data_data_ok_i = 0;
      #1 chk("flush after drain", {30'h0, stall_o, done_o}, 0);
      @(negedge clk);
      #1 chk("flush no late done", 32'(done_o), 0);
      run_chk("after flush LW", OP_LW, 32'h4004, 32'h0, 32'h1357_9bdf, 0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         op = ops[$urandom_range(0, 11)];
         addr = $urandom;
         if (m_err(op, addr)) err_case($sformatf("rnd%0d", i), op, addr, m_load(op), !m_load(op));
         else run_chk($sformatf("rnd%0d", i), op, addr, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
